// File: rtl/alu_pkg.sv
// Shared ALU-64 definitions: operation modes and sequencer state encoding.
package alu_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/aq_step.sv
// One combinational iteration of the A/Q datapath: Booth radix-2 multiply step
// or restoring divide step, selected by mode.
module aq_step
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic         q1,
  input  logic [W:0]   m,
  input  logic         mode,
  output logic [W:0]   a_nxt,
  output logic [W-1:0] q_nxt,
  output logic         q1_nxt
);

  logic signed [W:0] sum;
  logic [W:0]        a_sh;
  logic [W-1:0]      q_sh;
  logic [W:0]        diff;

  always_comb begin
    sum    = a;
    a_sh   = {a[W-1:0], q[W-1]};
    q_sh   = {q[W-2:0], 1'b0};
    diff   = a_sh - m;
    a_nxt  = a;
    q_nxt  = q;
    q1_nxt = q1;

    if (mode == MODE_MUL) begin
      case ({q[0], q1})
        2'b01:   sum = a + m;
        2'b10:   sum = a - m;
        default: sum = a;
      endcase
      // Arithmetic shift of {A,Q,Q_1}: A's sign bit replicates into the top.
      a_nxt  = {sum[W], sum[W:1]};
      q_nxt  = {sum[0], q[W-1:1]};
      q1_nxt = q[0];
    end else begin
      // A negative trial difference means the divisor did not fit: restore.
      if (diff[W]) begin
        a_nxt = a_sh;
        q_nxt = q_sh;
      end else begin
        a_nxt = diff;
        q_nxt = q_sh | {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/aq_seq_unit.sv
// Multi-cycle signed multiply / unsigned divide: A/Q register pair, iteration
// counter and IDLE/RUN/DONE sequencer with a divide-by-zero bypass.
module aq_seq_unit
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  localparam int CW = $clog2(W + 1);

  state_t         state, state_nxt;
  logic [W:0]     a_r, m_r;
  logic [W-1:0]   q_r;
  logic           q1_r;
  logic [CW-1:0]  cnt_r;
  logic           mode_r;
  logic           dbz_r;

  logic [W:0]     a_step;
  logic [W-1:0]   q_step;
  logic           q1_step;
  logic           accept;
  logic           zero_div;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign zero_div = (mode == MODE_DIV) && (op_a == '0);

  aq_step #(.W(W)) u_step (
    .a      (a_r),
    .q      (q_r),
    .q1     (q1_r),
    .m      (m_r),
    .mode   (mode_r),
    .a_nxt  (a_step),
    .q_nxt  (q_step),
    .q1_nxt (q1_step)
  );

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = zero_div ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     state_nxt = (cnt_r == CW'(1)) ? DONE : RUN;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      a_r    <= '0;
      q_r    <= '0;
      q1_r   <= 1'b0;
      m_r    <= '0;
      cnt_r  <= '0;
      mode_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_r <= mode;
        dbz_r  <= zero_div;
        cnt_r  <= CW'(W);
        q1_r   <= 1'b0;
        // Divide by zero skips iteration and presents the final result directly.
        if (zero_div) begin
          a_r <= {1'b0, op_b};
          q_r <= '1;
          m_r <= '0;
        end else begin
          a_r <= '0;
          q_r <= op_b;
          m_r <= (mode == MODE_MUL) ? {op_a[W-1], op_a} : {1'b0, op_a};
        end
      end else if (state == RUN) begin
        a_r   <= a_step;
        q_r   <= q_step;
        q1_r  <= q1_step;
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign div_by_zero = dbz_r;
  assign res_hi      = a_r[W-1:0];
  assign res_lo      = q_r;

endmodule

// File: tb/tb_aq_seq_unit.sv
// Self-checking bench for aq_seq_unit at W=16, W=8 and W=64 against an
// arithmetic reference model.
module tb_aq_seq_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        s16, m16, busy16, done16, dbz16;
  logic [15:0] a16, b16, hi16, lo16;
  logic        s8, m8, busy8, done8, dbz8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        s64, m64, busy64, done64, dbz64;
  logic [63:0] a64, b64, hi64, lo64;

  aq_seq_unit #(.W(16)) dut16 (
    .clk(clk), .rst_b(rst_b), .start(s16), .mode(m16), .op_a(a16), .op_b(b16),
    .busy(busy16), .done(done16), .div_by_zero(dbz16), .res_hi(hi16), .res_lo(lo16)
  );
  aq_seq_unit #(.W(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(s8), .mode(m8), .op_a(a8), .op_b(b8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .res_hi(hi8), .res_lo(lo8)
  );
  aq_seq_unit #(.W(64)) dut64 (
    .clk(clk), .rst_b(rst_b), .start(s64), .mode(m64), .op_a(a64), .op_b(b64),
    .busy(busy64), .done(done64), .div_by_zero(dbz64), .res_hi(hi64), .res_lo(lo64)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {res_hi,res_lo} from plain arithmetic on w-bit operands.
  function automatic logic [127:0] model(input int w, input logic md,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0]  sa, sb;
    logic signed [127:0] p;
    logic [127:0]        mask, q, r;
    sa   = $signed(a << (64 - w)) >>> (64 - w);
    sb   = $signed(b << (64 - w)) >>> (64 - w);
    mask = (128'h1 << (2 * w)) - 128'h1;
    if (!md) begin
      p = 128'(sa) * 128'(sb);
      return p & mask;
    end
    if (a == 64'h0)
      return (128'(b) << w) | ((128'h1 << w) - 128'h1);
    q = 128'(b / a);
    r = 128'(b % a);
    return (r << w) | q;
  endfunction

  task automatic launch16(input logic md, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    s16 = 1'b1; m16 = md; a16 = a; b16 = b;
    @(negedge clk);
    s16 = 1'b0;
  endtask

  task automatic wait16(output int n, output int nb);
    n = 0; nb = 0;
    while (!done16 && n < 200) begin
      if (busy16) nb++;
      @(negedge clk);
      n++;
    end
    if (!done16) chk("timeout16", done16, 1);
  endtask

  task automatic run16(input logic md, input logic [15:0] a, input logic [15:0] b,
                       output int n, output int nb, output logic [127:0] res, output logic dbz);
    launch16(md, a, b);
    wait16(n, nb);
    res = {96'h0, hi16, lo16};
    dbz = dbz16;
  endtask

  task automatic run8(input logic md, input logic [7:0] a, input logic [7:0] b,
                      output int n, output int nb, output logic [127:0] res, output logic dbz);
    @(negedge clk);
    s8 = 1'b1; m8 = md; a8 = a; b8 = b;
    @(negedge clk);
    s8 = 1'b0;
    n = 0; nb = 0;
    while (!done8 && n < 200) begin
      if (busy8) nb++;
      @(negedge clk);
      n++;
    end
    if (!done8) chk("timeout8", done8, 1);
    res = {112'h0, hi8, lo8};
    dbz = dbz8;
  endtask

  task automatic run64(input logic md, input logic [63:0] a, input logic [63:0] b,
                       output int n, output int nb, output logic [127:0] res, output logic dbz);
    @(negedge clk);
    s64 = 1'b1; m64 = md; a64 = a; b64 = b;
    @(negedge clk);
    s64 = 1'b0;
    n = 0; nb = 0;
    while (!done64 && n < 300) begin
      if (busy64) nb++;
      @(negedge clk);
      n++;
    end
    if (!done64) chk("timeout64", done64, 1);
    res = {hi64, lo64};
    dbz = dbz64;
  endtask

  task automatic check_op(input string tag, input int w, input logic md,
                          input logic [63:0] a, input logic [63:0] b,
                          input int n, input int nb, input logic [127:0] res, input logic dbz);
    logic zd;
    zd = md && (a == 64'h0);
    chk({tag, "_res"},  res, model(w, md, a, b));
    chk({tag, "_lat"},  128'(n),  zd ? 128'd0 : 128'(w));
    chk({tag, "_busy"}, 128'(nb), zd ? 128'd0 : 128'(w));
    chk({tag, "_dbz"},  128'(dbz), 128'(zd));
  endtask

  initial begin
    int n, nb;
    logic [127:0] res;
    logic dbz;
    logic md;
    logic [63:0] ra, rb;

    s16 = 0; m16 = 0; a16 = 0; b16 = 0;
    s8  = 0; m8  = 0; a8  = 0; b8  = 0;
    s64 = 0; m64 = 0; a64 = 0; b64 = 0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_dbz",  dbz16, 0);
    chk("rst_res",  {hi16, lo16}, 0);
    rst_b = 1'b1;

    // Directed W=16 cases with hand-computed results.
    run16(1'b0, 16'd3, 16'hFFFB, n, nb, res, dbz);
    chk("mul_3x-5", res, 128'hFFFF_FFF1);
    check_op("mul_3x-5", 16, 1'b0, 64'd3, 64'hFFFB, n, nb, res, dbz);
    run16(1'b0, 16'h8000, 16'h8000, n, nb, res, dbz);
    chk("mul_min_min", res, 128'h4000_0000);
    run16(1'b0, 16'h8000, 16'h0001, n, nb, res, dbz);
    chk("mul_min_1", res, 128'hFFFF_8000);
    run16(1'b1, 16'h0000, 16'h1234, n, nb, res, dbz);
    chk("dbz_lo", lo16, 16'hFFFF);
    chk("dbz_hi", hi16, 16'h1234);
    chk("dbz_flag", dbz, 1);
    chk("dbz_lat", n, 0);
    chk("dbz_busy", nb, 0);
    @(negedge clk);
    chk("dbz_idle_busy", busy16, 0);
    chk("dbz_hold_hi", hi16, 16'h1234);
    run16(1'b1, 16'd7, 16'd100, n, nb, res, dbz);
    chk("div_100_7_lo", lo16, 16'd14);
    chk("div_100_7_hi", hi16, 16'd2);
    chk("div_100_7_dbz", dbz, 0);
    chk("div_100_7_lat", n, 16);
    run16(1'b1, 16'd1, 16'hFFFF, n, nb, res, dbz);
    chk("div_ffff_1", res, 128'h0000_FFFF);

    // Start pulses during RUN must be ignored.
    launch16(1'b0, 16'd3, 16'hFFFB);
    repeat (3) @(negedge clk);
    s16 = 1'b1; m16 = 1'b1; a16 = 16'h0000; b16 = 16'h5555;
    @(negedge clk);
    s16 = 1'b0;
    wait16(n, nb);
    chk("ign_res", {hi16, lo16}, 32'hFFFF_FFF1);
    chk("ign_dbz", dbz16, 0);
    chk("ign_lat", n, 12);

    // Back-to-back: start held in DONE launches the next op without an idle cycle.
    launch16(1'b0, 16'h7FFF, 16'h7FFF);
    wait16(n, nb);
    chk("b2b_first", {hi16, lo16}, 32'h3FFF_0001);
    s16 = 1'b1; m16 = 1'b1; a16 = 16'd7; b16 = 16'd100;
    @(negedge clk);
    s16 = 1'b0;
    chk("b2b_busy", busy16, 1);
    wait16(n, nb);
    chk("b2b_lat", n, 16);
    chk("b2b_res", {hi16, lo16}, 32'h0002_000E);

    // Asynchronous reset mid-operation aborts without a done pulse.
    launch16(1'b0, 16'd1234, 16'd77);
    repeat (5) @(negedge clk);
    chk("abort_busy_before", busy16, 1);
    rst_b = 1'b0;
    #1;
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_dbz", dbz16, 0);
    chk("abort_res", {hi16, lo16}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", done16, 0);
    end
    rst_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_nodone_rel", done16, 0);
    end
    run16(1'b1, 16'd9, 16'd1000, n, nb, res, dbz);
    check_op("after_rst", 16, 1'b1, 64'd9, 64'd1000, n, nb, res, dbz);

    // Random W=16 operations.
    for (int i = 0; i < 20; i++) begin
      md = 1'($urandom_range(0, 1));
      ra = 64'($urandom_range(0, 16'hFFFF));
      rb = 64'($urandom_range(0, 16'hFFFF));
      run16(md, ra[15:0], rb[15:0], n, nb, res, dbz);
      check_op("rnd16", 16, md, ra, rb, n, nb, res, dbz);
    end

    // W=8 sweep, including small divisors and occasional zero divisor.
    for (int i = 0; i < 60; i++) begin
      md = 1'(i % 2);
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      if (i % 15 == 1) ra = 64'h0;
      run8(md, ra[7:0], rb[7:0], n, nb, res, dbz);
      check_op("rnd8", 8, md, ra, rb, n, nb, res, dbz);
    end

    // W=64.
    run64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, n, nb, res, dbz);
    chk("w64_m1xm1", res, 128'h1);
    check_op("w64_m1xm1", 64, 1'b0, '1, '1, n, nb, res, dbz);
    for (int i = 0; i < 4; i++) begin
      md = 1'(i % 2);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run64(md, ra, rb, n, nb, res, dbz);
      check_op("rnd64", 64, md, ra, rb, n, nb, res, dbz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
